// File: rtl/sw_num_scan.sv
// Debounced 4-bit DIP switch with a short history of distinct values, shown on a
// time-multiplexed bank of seven-segment digits. Define HEX_DISPLAY_EN to decode values 10..15 as A..F.
module sw_num_scan #(
  parameter int          DIGITS     = 8,
  parameter int          HIST_DEPTH = 3,
  parameter logic [15:0] DEB_CYCLES = 16'd50000,
  parameter logic [15:0] SCAN_DIV   = 16'd10000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [3:0]        switch,
  output logic [DIGITS-1:0] num_csn,
  output logic [6:0]        num_a_g,
  output logic [3:0]        led
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [3:0]                       s1_q, s1_d, s2_q, s2_d;
  logic [3:0]                       cand_q, cand_d, stable_q, stable_d;
  logic [15:0]                      cnt_q, cnt_d;
  logic [HIST_DEPTH-1:0][3:0]       hist_q, hist_d;
  logic [DIGITS-1:0][6:0]           seg_q, seg_d;
  logic [DIGITS-1:0][3:0]           val;
  logic [15:0]                      pcnt_q, pcnt_d;
  logic [IW-1:0]                    idx_q, idx_d;
  logic [DIGITS-1:0]                num_csn_q, num_csn_d;
  logic [6:0]                       num_a_g_q, num_a_g_d;
  logic                             scan_wrap;

  // Values with no glyph return prev, so the digit keeps whatever it showed last.
  function automatic logic [6:0] seg_decode(input logic [3:0] v, input logic [6:0] prev);
    case (v)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
`ifdef HEX_DISPLAY_EN
      4'd10:   return 7'b1110111;
      4'd11:   return 7'b0011111;
      4'd12:   return 7'b1001110;
      4'd13:   return 7'b0111101;
      4'd14:   return 7'b1001111;
      4'd15:   return 7'b1000111;
`endif
      default: return prev;
    endcase
  endfunction

  always_comb begin
    s1_d     = ~switch;
    s2_d     = s1_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    hist_d   = hist_q;

    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q == DEB_CYCLES - 16'd1) begin
      stable_d = cand_q;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end

    // Only a real change of the settled value pushes history; re-writes are ignored.
    if (stable_d != stable_q) begin
      hist_d[0] = stable_q;
      for (int i = 1; i < HIST_DEPTH; i++) hist_d[i] = hist_q[i-1];
    end
  end

  always_comb begin
    val    = '0;
    val[0] = stable_q;
    for (int k = 1; k <= HIST_DEPTH; k++) val[k] = hist_q[k-1];
    seg_d = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (k <= HIST_DEPTH) seg_d[k] = seg_decode(val[k], seg_q[k]);
    end
  end

  always_comb begin
    scan_wrap = (pcnt_q == SCAN_DIV - 16'd1);
    pcnt_d    = scan_wrap ? '0 : pcnt_q + 16'd1;
    idx_d     = idx_q;
    if (scan_wrap) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    num_csn_d = ~(DIGITS'(1) << idx_q);
    num_a_g_d = seg_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_q      <= '0;
      s2_q      <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      stable_q  <= '0;
      hist_q    <= '0;
      seg_q     <= '0;
      pcnt_q    <= '0;
      idx_q     <= '0;
      num_csn_q <= '1;
      num_a_g_q <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      hist_q    <= hist_d;
      seg_q     <= seg_d;
      pcnt_q    <= pcnt_d;
      idx_q     <= idx_d;
      num_csn_q <= num_csn_d;
      num_a_g_q <= num_a_g_d;
    end
  end

  assign num_csn = num_csn_q;
  assign num_a_g = num_a_g_q;
  assign led     = ~hist_q[0];

endmodule

// File: tb/tb_sw_num_scan.sv
// Randomised bench for sw_num_scan: a sliding-window debounce/history/scan model checked every cycle.
module tb_sw_num_scan;
  localparam int D = 4, H = 3, DEB = 4, SD = 3;
`ifdef HEX_DISPLAY_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] switch;
  logic [3:0] num_csn;
  logic [6:0] num_a_g;
  logic [3:0] led;

  sw_num_scan #(.DIGITS(D), .HIST_DEPTH(H), .DEB_CYCLES(16'd4), .SCAN_DIV(16'd3)) dut (
    .clk(clk), .resetn(resetn), .switch(switch),
    .num_csn(num_csn), .num_a_g(num_a_g), .led(led)
  );

  always #5 clk = ~clk;

  logic [6:0] DEC [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: raw samples per edge; a value settles once it filled the whole sampled window.
  logic [4:0] q[$];
  logic [3:0] m_stable, m_led, m_csn, v4;
  logic [3:0] m_hist [H];
  logic [3:0] m_val  [D];
  logic [6:0] m_seg  [D];
  logic [6:0] n_seg  [D];
  logic [6:0] m_ag;
  logic [4:0] w;
  bit         same, chk_en = 1'b0;
  int         e, idx;

  always @(posedge clk) begin
    if (!resetn) begin
      q.delete();
      q.push_back(5'h10);
      q.push_back(5'h00);
      q.push_back(5'h00);
      q.push_back(5'h00);
      m_stable = '0;
      for (int i = 0; i < H; i++) m_hist[i] = '0;
      for (int k = 0; k < D; k++) m_seg[k] = '0;
      e = 0; m_csn = 4'hF; m_ag = '0;
      chk_en = 1'b1;
    end else begin
      idx = (e / SD) % D;
      e++;
      m_csn = ~(4'b0001 << idx);
      m_ag  = m_seg[idx];
      for (int k = 0; k < D; k++) m_val[k] = '0;
      m_val[0] = m_stable;
      for (int k = 1; k <= H; k++) m_val[k] = m_hist[k-1];
      for (int k = 0; k < D; k++) begin
        if (k > H)                      n_seg[k] = '0;
        else if (m_val[k] < 10 || HEX)  n_seg[k] = DEC[m_val[k]];
        else                            n_seg[k] = m_seg[k];
      end
      q.push_back({1'b0, ~switch});
      if (q.size() >= DEB + 3) begin
        w = q[q.size()-3];
        same = 1'b1;
        for (int j = 0; j <= DEB; j++) if (q[q.size()-3-j] != w) same = 1'b0;
        if (same && !w[4] && w[3:0] != m_stable) begin
          for (int i = H - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
          m_hist[0] = m_stable;
          m_stable  = w[3:0];
        end
      end
      if (q.size() > 32) void'(q.pop_front());
      for (int k = 0; k < D; k++) m_seg[k] = n_seg[k];
    end
    m_led = ~m_hist[0];
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("csn", num_csn, m_csn);
      chk("a_g", num_a_g, m_ag);
      chk("led", led, m_led);
    end
  end

  task automatic set_val(input logic [3:0] v, input int n);
    switch = ~v;
    repeat (n) @(negedge clk);
  endtask

  logic [6:0] cap [D];
  int         pat_cnt [D];
  bit         found;

  initial begin
    resetn = 1'b0; switch = 4'b1010;
    repeat (3) @(negedge clk);
    chk("rst_csn", num_csn, 4'hF);
    chk("rst_ag", num_a_g, 7'h0);
    chk("rst_led", led, 4'hF);

    resetn = 1'b1; switch = 4'hF;
    @(negedge clk);
    chk("rel1_csn", num_csn, 4'b1110);
    chk("rel1_ag", num_a_g, 7'h0);
    @(negedge clk);
    chk("rel2_ag", num_a_g, 7'b1111110);
    repeat (6) @(negedge clk);

    // Short glitch must not settle; a held value settles on the 7th edge.
    set_val(4'd1, 3);
    set_val(4'd0, 10);
    chk("glitch_stable", dut.stable_q, 4'd0);
    chk("glitch_led", led, 4'hF);
    switch = ~4'd1;
    repeat (6) @(negedge clk);
    chk("deb6_model", m_stable, 4'd0);
    chk("deb6_dut", dut.stable_q, 4'd0);
    @(negedge clk);
    chk("deb7_model", m_stable, 4'd1);
    chk("deb7_dut", dut.stable_q, 4'd1);
    chk("deb7_led", led, 4'hF);
    repeat (10) @(negedge clk);

    set_val(4'd3, 10);
    set_val(4'd5, 10);
    set_val(4'd9, 10);
    set_val(4'd2, 10);
    chk("hist_led", led, 4'b0110);
    chk("hist0_model", m_hist[0], 4'd9);
    chk("hist1_model", m_hist[1], 4'd5);
    chk("hist2_model", m_hist[2], 4'd3);
    for (int k = 0; k < D; k++) cap[k] = 7'h7F;
    for (int i = 0; i < D * SD; i++) begin
      @(negedge clk);
      for (int k = 0; k < D; k++) if (num_csn == ~(4'b0001 << k)) cap[k] = num_a_g;
    end
    chk("frame_d0", cap[0], 7'b1101101);
    chk("frame_d1", cap[1], 7'b1111011);
    chk("frame_d2", cap[2], 7'b1011011);
    chk("frame_d3", cap[3], 7'b1111001);

    for (int k = 0; k < D; k++) pat_cnt[k] = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      for (int k = 0; k < D; k++) if (num_csn == ~(4'b0001 << k)) pat_cnt[k]++;
    end
    for (int k = 0; k < D; k++) chk($sformatf("scan_slot%0d", k), pat_cnt[k], 6);

    set_val(4'd12, 12);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (num_csn == 4'b1110) found = 1'b1;
    end
    chk("v12_found", {31'b0, found}, 32'd1);
    chk("v12_d0", num_a_g, HEX ? 7'b1001110 : 7'b1101101);
    chk("v12_led", led, 4'b1101);
    chk("v12_hist0", m_hist[0], 4'd2);

    for (int i = 0; i < 80; i++) set_val(4'($urandom_range(0, 15)), $urandom_range(1, 9));

    set_val(4'd6, 10);
    set_val(4'd7, 10);
    chk("pre_rst_led", led, 4'b1001);
    switch = ~4'd5;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_led", led, 4'hF);
    chk("mid_rst_csn", num_csn, 4'hF);
    chk("mid_rst_ag", num_a_g, 7'h0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    switch = 4'hF;
    repeat (12) @(negedge clk);
    chk("post_rst_stable", dut.stable_q, 4'd0);
    chk("post_rst_led", led, 4'hF);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
